// File: rtl/lc3b_datapath_ext_pkg.sv
// lc3b_types: shared opcode, ALU operation, condition-code and mux-select
// types for the parametrised LC-3b datapath and its control FSM.
package lc3b_types;

    typedef enum logic [3:0] {
        op_br   = 4'h0,
        op_add  = 4'h1,
        op_ldb  = 4'h2,
        op_stb  = 4'h3,
        op_jsr  = 4'h4,
        op_and  = 4'h5,
        op_ldr  = 4'h6,
        op_str  = 4'h7,
        op_rti  = 4'h8,
        op_not  = 4'h9,
        op_ldi  = 4'ha,
        op_sti  = 4'hb,
        op_jmp  = 4'hc,
        op_shf  = 4'hd,
        op_lea  = 4'he,
        op_trap = 4'hf
    } lc3b_opcode;

    typedef enum logic [2:0] {
        alu_add  = 3'd0,
        alu_and  = 3'd1,
        alu_not  = 3'd2,
        alu_pass = 3'd3,
        alu_sll  = 3'd4,
        alu_srl  = 3'd5,
        alu_sra  = 3'd6
    } lc3b_aluop;

    typedef logic [2:0] lc3b_nzp;

    typedef enum logic [1:0] {
        pcmux_plus2  = 2'd0,
        pcmux_br_add = 2'd1,
        pcmux_sr1    = 2'd2,
        pcmux_mdr    = 2'd3
    } pcmux_sel_t;

    typedef enum logic [1:0] {
        marmux_alu      = 2'd0,
        marmux_pc       = 2'd1,
        marmux_trapvect = 2'd2,
        marmux_mdr      = 2'd3
    } marmux_sel_t;

    typedef enum logic [2:0] {
        regfilemux_alu    = 3'd0,
        regfilemux_mdr    = 3'd1,
        regfilemux_br_add = 3'd2,
        regfilemux_pc     = 3'd3,
        regfilemux_byte   = 3'd4
    } regfilemux_sel_t;

    typedef enum logic [1:0] {
        alumux_sr2      = 2'd0,
        alumux_offset6  = 2'd1,
        alumux_imm5     = 2'd2,
        alumux_zoffset6 = 2'd3
    } alumux_sel_t;

    typedef enum logic {
        brmux_offset9  = 1'b0,
        brmux_offset11 = 1'b1
    } brmux_sel_t;

    typedef enum logic {
        storemux_sr1 = 1'b0,
        storemux_dr  = 1'b1
    } storemux_sel_t;

    typedef enum logic {
        destmux_dr = 1'b0,
        destmux_r7 = 1'b1
    } destmux_sel_t;

    typedef enum logic {
        mdrmux_alu = 1'b0,
        mdrmux_mem = 1'b1
    } mdrmux_sel_t;

    localparam lc3b_nzp RESET_CC = 3'b010;

endpackage

// File: rtl/lc3b_datapath_ext_byte_steer.sv
// lc3b_byte_steer: byte-lane steering for LDB/STB. Lane is MAR[0]; loads
// pick one MDR byte and zero-extend it, stores replicate the ALU byte into
// both lanes and enable only the addressed lane.
module lc3b_byte_steer
    import lc3b_types::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [15:0]      mdr_low,
    input  logic [7:0]       alu_byte,
    input  logic             lane,
    output logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] store_data,
    output logic [1:0]       byte_enable
);

    assign load_value  = lane ? WIDTH'(mdr_low[15:8]) : WIDTH'(mdr_low[7:0]);
    assign store_data  = WIDTH'({alu_byte, alu_byte});
    assign byte_enable = lane ? 2'b10 : 2'b01;

endmodule

// File: rtl/lc3b_datapath_ext.sv
// lc3b_datapath_ext: parametrised LC-3b multicycle datapath (PC, IR, MAR,
// MDR, CC, register file) with byte load/store, LEA, JSR/JSRR, TRAP and
// indirect-load steering. All sequencing lives in the control FSM.
// Optional feature macro: LC3B_DATAPATH_SHF_EN enables the SLL/SRL/SRA
// barrel shifter; without it shift aluops pass operand A through.
module lc3b_datapath_ext
    import lc3b_types::*;
#(
    parameter int             WIDTH    = 16,
    parameter int             NUM_REGS = 8,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_pc,
    input  logic            load_ir,
    input  logic            load_regfile,
    input  logic            load_mar,
    input  logic            load_mdr,
    input  logic            load_cc,
    input  pcmux_sel_t      pcmux_sel,
    input  marmux_sel_t     marmux_sel,
    input  regfilemux_sel_t regfilemux_sel,
    input  alumux_sel_t     alumux_sel,
    input  brmux_sel_t      brmux_sel,
    input  storemux_sel_t   storemux_sel,
    input  destmux_sel_t    destmux_sel,
    input  mdrmux_sel_t     mdrmux_sel,
    input  logic            byte_op,
    input  lc3b_aluop       aluop,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [WIDTH-1:0] mem_address,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [1:0]      mem_byte_enable,
    output lc3b_opcode      opcode,
    output logic            ir_bit4,
    output logic            ir_bit5,
    output logic            ir_bit11,
    output logic            branch_enable
);

    localparam int RW = $clog2(NUM_REGS);

    // Architectural state
    logic [WIDTH-1:0] pc;
    logic [15:0]      ir;
    logic [WIDTH-1:0] mar;
    logic [WIDTH-1:0] mdr;
    lc3b_nzp          cc;
    logic [WIDTH-1:0] regs [NUM_REGS];

    // Datapath nets
    logic [RW-1:0]    sr1_idx;
    logic [RW-1:0]    sr2_idx;
    logic [RW-1:0]    dest_idx;
    logic [WIDTH-1:0] sr1_data;
    logic [WIDTH-1:0] sr2_data;
    logic signed [WIDTH-1:0] sext_imm5;
    logic signed [WIDTH-1:0] sext_off6;
    logic signed [WIDTH-1:0] sext_off9;
    logic signed [WIDTH-1:0] sext_off11;
    logic [WIDTH-1:0] zext_off6;
    logic [WIDTH-1:0] trap_addr;
    logic [WIDTH-1:0] pc_plus2;
    logic [WIDTH-1:0] brmux_out;
    logic [WIDTH-1:0] br_add;
    logic [WIDTH-1:0] alumux_out;
    logic [WIDTH-1:0] alu_out;
    logic [WIDTH-1:0] pcmux_out;
    logic [WIDTH-1:0] marmux_out;
    logic [WIDTH-1:0] mdrmux_out;
    logic [WIDTH-1:0] regfilemux_out;
    logic [WIDTH-1:0] byte_load_value;
    logic [WIDTH-1:0] byte_store_data;
    logic [1:0]       byte_lane_enable;

`ifdef LC3B_DATAPATH_SHF_EN
    logic signed [WIDTH-1:0] sr1_signed;
    logic [3:0]              shift_amt;
    assign sr1_signed = sr1_data;
    assign shift_amt  = ir[3:0];
`endif

    // N if MSB set, Z if zero, P otherwise: exactly one bit is ever set.
    function automatic lc3b_nzp gencc(input logic [WIDTH-1:0] value);
        if (value[WIDTH-1])
            return 3'b100;
        else if (value == '0)
            return 3'b010;
        else
            return 3'b001;
    endfunction

    // Instruction fields, always from the low 16 IR bits
    assign sext_imm5  = WIDTH'($signed(ir[4:0]));
    assign sext_off6  = WIDTH'($signed(ir[5:0]));
    assign sext_off9  = WIDTH'($signed(ir[8:0]));
    assign sext_off11 = WIDTH'($signed(ir[10:0]));
    assign zext_off6  = WIDTH'(ir[5:0]);
    assign trap_addr  = WIDTH'({ir[7:0], 1'b0});

    // Register file indices; R7 is the only linkage target
    assign sr1_idx  = (storemux_sel == storemux_dr) ? RW'(ir[11:9]) : RW'(ir[8:6]);
    assign sr2_idx  = RW'(ir[2:0]);
    assign dest_idx = (destmux_sel == destmux_r7) ? RW'(3'd7) : RW'(ir[11:9]);
    assign sr1_data = regs[sr1_idx];
    assign sr2_data = regs[sr2_idx];

    // Address arithmetic wraps modulo 2^WIDTH
    assign pc_plus2  = pc + WIDTH'(2);
    assign brmux_out = (brmux_sel == brmux_offset11) ? (sext_off11 <<< 1) : (sext_off9 <<< 1);
    assign br_add    = pc + brmux_out;

    // ALU operand B select
    always_comb begin
        alumux_out = sr2_data;
        case (alumux_sel)
            alumux_sr2:      alumux_out = sr2_data;
            alumux_offset6:  alumux_out = sext_off6 <<< 1;
            alumux_imm5:     alumux_out = sext_imm5;
            alumux_zoffset6: alumux_out = zext_off6;
            default:         alumux_out = sr2_data;
        endcase
    end

    // ALU; IR[4] picks arithmetic vs logical right shift when shifts exist
    always_comb begin
        alu_out = sr1_data;
        case (aluop)
            alu_add:  alu_out = sr1_data + alumux_out;
            alu_and:  alu_out = sr1_data & alumux_out;
            alu_not:  alu_out = ~sr1_data;
            alu_pass: alu_out = sr1_data;
`ifdef LC3B_DATAPATH_SHF_EN
            alu_sll:  alu_out = sr1_data << shift_amt;
            alu_srl, alu_sra: begin
                if (ir[4])
                    alu_out = sr1_signed >>> shift_amt;
                else
                    alu_out = sr1_data >> shift_amt;
            end
`endif
            default:  alu_out = sr1_data;
        endcase
    end

    lc3b_byte_steer #(
        .WIDTH(WIDTH)
    ) u_byte_steer (
        .mdr_low     (mdr[15:0]),
        .alu_byte    (alu_out[7:0]),
        .lane        (mar[0]),
        .load_value  (byte_load_value),
        .store_data  (byte_store_data),
        .byte_enable (byte_lane_enable)
    );

    // PC, MAR, MDR and register-file write data selects
    always_comb begin
        pcmux_out = pc_plus2;
        case (pcmux_sel)
            pcmux_plus2:  pcmux_out = pc_plus2;
            pcmux_br_add: pcmux_out = br_add;
            pcmux_sr1:    pcmux_out = sr1_data;
            pcmux_mdr:    pcmux_out = mdr;
            default:      pcmux_out = pc_plus2;
        endcase

        marmux_out = alu_out;
        case (marmux_sel)
            marmux_alu:      marmux_out = alu_out;
            marmux_pc:       marmux_out = pc;
            marmux_trapvect: marmux_out = trap_addr;
            marmux_mdr:      marmux_out = mdr;
            default:         marmux_out = alu_out;
        endcase

        mdrmux_out = alu_out;
        if (mdrmux_sel == mdrmux_mem)
            mdrmux_out = mem_rdata;
        else if (byte_op)
            mdrmux_out = byte_store_data;

        regfilemux_out = alu_out;
        case (regfilemux_sel)
            regfilemux_alu:    regfilemux_out = alu_out;
            regfilemux_mdr:    regfilemux_out = mdr;
            regfilemux_br_add: regfilemux_out = br_add;
            regfilemux_pc:     regfilemux_out = pc;
            regfilemux_byte:   regfilemux_out = byte_load_value;
            default:           regfilemux_out = alu_out;
        endcase
    end

    // Special registers: reset overrides every load strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            pc  <= RESET_PC;
            ir  <= '0;
            mar <= '0;
            mdr <= '0;
            cc  <= RESET_CC;
        end else begin
            if (load_pc)  pc  <= pcmux_out;
            if (load_ir)  ir  <= mdr[15:0];
            if (load_mar) mar <= marmux_out;
            if (load_mdr) mdr <= mdrmux_out;
            if (load_cc)  cc  <= gencc(regfilemux_out);
        end
    end

    // Register file write port; reads above are unbypassed
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (load_regfile) begin
            regs[dest_idx] <= regfilemux_out;
        end
    end

    assign mem_address     = mar;
    assign mem_wdata       = mdr;
    assign mem_byte_enable = byte_op ? byte_lane_enable : 2'b11;
    assign opcode          = lc3b_opcode'(ir[15:12]);
    assign ir_bit4         = ir[4];
    assign ir_bit5         = ir[5];
    assign ir_bit11        = ir[11];
    assign branch_enable   = |(ir[11:9] & cc);

endmodule
